// File: rtl/bincnt_seq.sv
// Sequential population counter: counts ones (or zeros) of an operand CHUNK bits
// per clock and presents the count in binary and in MSB-packed thermometer form.
module bincnt_seq #(
    parameter int WIDTH = 8,
    parameter int CHUNK = 2,
    localparam int CW  = $clog2(WIDTH + 1),
    localparam int NCH = WIDTH / CHUNK
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_zeros,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CW-1:0]    out_count,
    output logic [WIDTH-1:0] out_therm,
    output logic [1:0]       o_dbg_state
);

    // Handshake: a transfer happens on a rising edge where valid and ready are both 1;
    // valid never depends on ready, and the payload is held unchanged while valid=1 and ready=0.

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam int NW = (NCH > 1) ? $clog2(NCH) : 1;

    logic [1:0]       r_state;
    logic [WIDTH-1:0] r_shift;
    logic [CW-1:0]    r_acc;
    logic [NW-1:0]    r_cnt;
    logic [CW-1:0]    r_count;
    logic [WIDTH-1:0] r_therm;

    logic [CW-1:0]    w_chunk_pop;
    logic [CW-1:0]    w_acc_next;
    logic [WIDTH-1:0] w_therm_next;
    logic             w_last_chunk;

    always_comb begin
        w_chunk_pop = '0;
        for (int i = 0; i < CHUNK; i++) begin
            w_chunk_pop = w_chunk_pop + CW'(r_shift[i]);
        end
    end

    assign w_acc_next   = r_acc + w_chunk_pop;
    assign w_last_chunk = (r_cnt == NW'(NCH - 1));

    // Thermometer bit WIDTH-1-j is set when the count exceeds j.
    always_comb begin
        w_therm_next = '0;
        for (int j = 0; j < WIDTH; j++) begin
            w_therm_next[WIDTH-1-j] = (w_acc_next > CW'(j));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_shift <= '0;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_count <= '0;
            r_therm <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_shift <= in_zeros ? ~in_data : in_data;
                        r_acc   <= '0;
                        r_cnt   <= '0;
                        r_state <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    r_shift <= r_shift >> CHUNK;
                    r_acc   <= w_acc_next;
                    r_cnt   <= r_cnt + NW'(1);
                    if (w_last_chunk) begin
                        r_count <= w_acc_next;
                        r_therm <= w_therm_next;
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    // Result outputs return to zero as soon as they are consumed.
                    if (out_ready) begin
                        r_count <= '0;
                        r_therm <= '0;
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign in_ready    = (r_state == S_IDLE);
    assign out_valid   = (r_state == S_DONE);
    assign out_count   = r_count;
    assign out_therm   = r_therm;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_bincnt_seq.sv
// Bench for bincnt_seq: directed vector table, hold/reset corner sequences,
// CHUNK=8 / CHUNK=1 latency checks, and a randomized stream against a popcount model.
module tb_bincnt_seq;

    localparam int W   = 8;
    localparam int CWB = 4;
    localparam int NCH = 4;

    logic           clk;
    logic           rst_n;
    logic           in_valid;
    logic [W-1:0]   in_data;
    logic           in_zeros;
    logic           out_ready;

    logic           in_ready, out_valid;
    logic [CWB-1:0] out_count;
    logic [W-1:0]   out_therm;
    logic [1:0]     dbg_state;

    logic           c8_in_ready, c8_out_valid;
    logic [CWB-1:0] c8_out_count;
    logic [W-1:0]   c8_out_therm;
    logic [1:0]     c8_dbg_state;

    logic           c1_in_ready, c1_out_valid;
    logic [CWB-1:0] c1_out_count;
    logic [W-1:0]   c1_out_therm;
    logic [1:0]     c1_dbg_state;

    int checks = 0;
    int errors = 0;

    bincnt_seq #(.WIDTH(8), .CHUNK(2)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_zeros(in_zeros), .out_valid(out_valid),
        .out_ready(out_ready), .out_count(out_count), .out_therm(out_therm),
        .o_dbg_state(dbg_state)
    );

    bincnt_seq #(.WIDTH(8), .CHUNK(8)) u_c8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(c8_in_ready),
        .in_data(in_data), .in_zeros(in_zeros), .out_valid(c8_out_valid),
        .out_ready(out_ready), .out_count(c8_out_count), .out_therm(c8_out_therm),
        .o_dbg_state(c8_dbg_state)
    );

    bincnt_seq #(.WIDTH(8), .CHUNK(1)) u_c1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(c1_in_ready),
        .in_data(in_data), .in_zeros(in_zeros), .out_valid(c1_out_valid),
        .out_ready(out_ready), .out_count(c1_out_count), .out_therm(c1_out_therm),
        .o_dbg_state(c1_dbg_state)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0]   data;
        logic           zeros;
        logic [CWB-1:0] exp_count;
        logic [W-1:0]   exp_therm;
    } vec_t;

    typedef struct {
        logic [CWB-1:0] cnt;
        logic [W-1:0]   therm;
    } res_t;

    res_t exp_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] ref_therm(input int c);
        logic [15:0] t;
        t = ((16'd1 << c) - 16'd1) << (W - c);
        return t[W-1:0];
    endfunction

    function automatic int ref_pop(input logic [W-1:0] d, input logic z);
        return $countones(z ? ~d : d);
    endfunction

    // Driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic accept(input logic [W-1:0] d, input logic z);
        in_data  = d;
        in_zeros = z;
        in_valid = 1'b1;
        check("in_ready_before_accept", 64'(in_ready), 64'd1);
        tick();
        in_valid = 1'b0;
        in_data  = ~d;
        in_zeros = ~z;
    endtask

    task automatic wait_result(output int lat);
        lat = 0;
        while (!out_valid && lat < 20) begin
            tick();
            lat++;
        end
    endtask

    task automatic consume();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("consume_out_valid", 64'(out_valid), 64'd0);
        check("consume_in_ready", 64'(in_ready), 64'd1);
        check("consume_count_zero", 64'(out_count), 64'd0);
        check("consume_therm_zero", 64'(out_therm), 64'd0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
    endtask

    // Randomized stream against a one-operation-in-flight model
    task automatic random_stream(input int n_ops);
        bit   pending;
        int   age;
        int   done_cnt;
        int   cyc;
        res_t cur;
        bit   acc_fire;
        bit   con_fire;
        pending  = 0;
        age      = 0;
        done_cnt = 0;
        cyc      = 0;
        cur.cnt  = '0;
        cur.therm = '0;
        while (done_cnt < n_ops && cyc < 40000) begin
            in_valid  = ($urandom_range(0, 9) < 7);
            in_data   = W'($urandom);
            in_zeros  = $urandom_range(0, 1) == 1;
            out_ready = ($urandom_range(0, 1) == 1);
            @(negedge clk);
            check("rnd_in_ready", 64'(in_ready), 64'(!pending));
            check("rnd_out_valid", 64'(out_valid), 64'(pending && age >= NCH));
            if (pending && age >= NCH) begin
                check("rnd_count", 64'(out_count), 64'(cur.cnt));
                check("rnd_therm", 64'(out_therm), 64'(cur.therm));
            end else begin
                check("rnd_count_idle", 64'(out_count), 64'd0);
                check("rnd_therm_idle", 64'(out_therm), 64'd0);
            end
            acc_fire = in_valid && !pending;
            con_fire = pending && age >= NCH && out_ready;
            if (con_fire) begin
                check("rnd_scoreboard", 64'(exp_q.size()), 64'd1);
                if (exp_q.size() > 0) begin
                    cur = exp_q.pop_front();
                end
                pending = 0;
                done_cnt++;
            end else if (acc_fire) begin
                cur.cnt   = CWB'(ref_pop(in_data, in_zeros));
                cur.therm = ref_therm(ref_pop(in_data, in_zeros));
                exp_q.push_back(cur);
                pending = 1;
                age     = 0;
            end else if (pending && age < NCH) begin
                age++;
            end
            tick();
            cyc++;
        end
        check("rnd_ops_completed", 64'(done_cnt), 64'(n_ops));
        in_valid  = 1'b0;
        out_ready = 1'b0;
    endtask

    initial begin
        vec_t vecs[8];
        int   lat;
        int   lat8;
        int   lat1;

        vecs[0] = '{8'hB5, 1'b0, 4'd5, 8'hF8};
        vecs[1] = '{8'hB5, 1'b1, 4'd3, 8'hE0};
        vecs[2] = '{8'h00, 1'b0, 4'd0, 8'h00};
        vecs[3] = '{8'hFF, 1'b0, 4'd8, 8'hFF};
        vecs[4] = '{8'h00, 1'b1, 4'd8, 8'hFF};
        vecs[5] = '{8'h01, 1'b0, 4'd1, 8'h80};
        vecs[6] = '{8'h5A, 1'b0, 4'd4, 8'hF0};
        vecs[7] = '{8'h80, 1'b1, 4'd7, 8'hFE};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_zeros  = 1'b0;
        out_ready = 1'b0;
        #2;
        check("reset_out_valid", 64'(out_valid), 64'd0);
        check("reset_out_count", 64'(out_count), 64'd0);
        check("reset_out_therm", 64'(out_therm), 64'd0);
        repeat (3) tick();
        rst_n = 1'b1;
        check("reset_in_ready", 64'(in_ready), 64'd1);

        // Directed table; the first acceptance lands on the first edge after reset release
        for (int i = 0; i < 8; i++) begin
            accept(vecs[i].data, vecs[i].zeros);
            wait_result(lat);
            check("vec_latency", 64'(lat), 64'(NCH));
            check("vec_count", 64'(out_count), 64'(vecs[i].exp_count));
            check("vec_therm", 64'(out_therm), 64'(vecs[i].exp_therm));
            consume();
        end

        // Result held under back-pressure while in_valid toggles data
        accept(8'hFF, 1'b0);
        wait_result(lat);
        for (int k = 0; k < 10; k++) begin
            in_valid = 1'b1;
            in_data  = (k % 2 == 0) ? 8'h00 : 8'h0F;
            tick();
            check("hold_valid", 64'(out_valid), 64'd1);
            check("hold_count", 64'(out_count), 64'd8);
            check("hold_therm", 64'(out_therm), 64'hFF);
            check("hold_in_ready", 64'(in_ready), 64'd0);
        end
        in_valid = 1'b0;
        consume();

        // Asynchronous reset two cycles into an operation
        accept(8'hFF, 1'b0);
        repeat (2) tick();
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_out_valid", 64'(out_valid), 64'd0);
        check("async_rst_in_ready", 64'(in_ready), 64'd1);
        check("async_rst_count", 64'(out_count), 64'd0);
        tick();
        rst_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            check("post_rst_no_result", 64'(out_valid), 64'd0);
            check("post_rst_in_ready", 64'(in_ready), 64'd1);
            tick();
        end
        accept(8'h01, 1'b0);
        wait_result(lat);
        check("post_rst_latency", 64'(lat), 64'(NCH));
        check("post_rst_count", 64'(out_count), 64'd1);
        check("post_rst_therm", 64'(out_therm), 64'h80);
        consume();

        // CHUNK=8 and CHUNK=1 latency and result
        do_reset();
        accept(8'h5A, 1'b0);
        lat8 = 0;
        lat1 = 0;
        for (int k = 1; k <= 12; k++) begin
            if (c8_out_valid && lat8 == 0) lat8 = k - 1;
            if (c1_out_valid && lat1 == 0) lat1 = k - 1;
            tick();
        end
        check("c8_latency", 64'(lat8), 64'd1);
        check("c1_latency", 64'(lat1), 64'd8);
        check("c8_count", 64'(c8_out_count), 64'd4);
        check("c8_therm", 64'(c8_out_therm), 64'hF0);
        check("c1_count", 64'(c1_out_count), 64'd4);
        check("c1_therm", 64'(c1_out_therm), 64'hF0);
        consume();
        check("c8_consumed", 64'(c8_in_ready), 64'd1);
        check("c1_consumed", 64'(c1_in_ready), 64'd1);

        do_reset();
        random_stream(1000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
